// File: rtl/load_store_unit.sv
// Data-memory stage: turns an ALU-computed address and rs2 into a ready/ack memory transaction,
// stalls the core while it is in flight, and returns the sign/zero-extended load value.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            done,
  output logic            stall,
  output logic            lsu_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic logic access_ok(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [1:0] a);
    if (rd && wr) return 1'b0;
    case (f3)
      3'b000, 3'b100: return 1'b1;
      3'b001, 3'b101: return ~a[0];
      3'b010:         return (a == 2'b00);
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                  input logic [XLEN-1:0] rd);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = rd[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return rd;
    endcase
  endfunction

  logic [1:0]      state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            err_q, err_nx;
  logic            start, valid, accept;

  logic            we_p0;
  logic [2:0]      funct3_p0;
  logic [XLEN-1:0] addr_p0;
  logic [XLEN-1:0] wdata_p0;
  logic [3:0]      be_p0;

  assign start  = mem_read | mem_write;
  assign valid  = access_ok(mem_read, mem_write, funct3, addr[1:0]);
  assign accept = (state == IDLE) && start && valid;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          state_nx = valid ? BUSY : DONE;
          err_nx   = ~valid;
        end
      end
      BUSY: begin
        // an ack on the final allowed cycle still wins over the timeout
        if (mem_ack) begin
          state_nx = DONE;
          err_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
          if (cnt_nx == TMAX) begin
            state_nx = DONE;
            err_nx   = 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        err_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      err_q     <= 1'b0;
      load_data <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      err_q <= err_nx;
      if ((state == BUSY) && mem_ack && !we_p0)
        load_data <= load_extend(funct3_p0, addr_p0[1:0], mem_rdata);
    end
  end

  // request capture at accept; stable for the whole BUSY phase
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0     <= mem_write;
      funct3_p0 <= funct3;
      addr_p0   <= addr;
      wdata_p0  <= store_lanes(funct3, wdata);
      be_p0     <= byte_en(funct3, addr[1:0]);
    end
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = mem_req & we_p0;
  assign mem_addr  = mem_req ? {addr_p0[XLEN-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be_p0 : 4'b0000;
  assign mem_wdata = mem_req ? wdata_p0 : '0;
  assign done      = (state == DONE);
  assign lsu_err   = done & err_q;
  assign stall     = rst_n & (((state == IDLE) & start) | (state == BUSY));

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of single accesses plus hand-written
// sequences for reset, back-to-back start in DONE, late ack and reset mid-access.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] load_data;
  logic        done, stall, lsu_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;

  int n_chk  = 0;
  int n_fail = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .load_data(load_data),
    .done(done), .stall(stall), .lsu_err(lsu_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;    // BUSY cycle (1-based) carrying ack, 0 = never
    int          exp_cyc;   // stall cycles including the accept cycle
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic        exp_we;
    logic [31:0] exp_mwdata;
    logic        exp_err;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int  stalls;
    int  reqs;
    bit  got;
    @(posedge clk); #1;
    mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    addr = v.addr; wdata = v.wdata; mem_rdata = v.rdata; mem_ack = 1'b0;
    #1;
    chk($sformatf("v%0d accept_stall", i), {31'b0, stall}, 32'd1);
    chk($sformatf("v%0d accept_req", i), {31'b0, mem_req}, 32'd0);
    stalls = 1; reqs = 0; got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (done) got = 1;
      else begin
        if (stall) stalls++;
        if (mem_req) reqs++;
        chk($sformatf("v%0d be", i), {28'b0, mem_be}, {28'b0, v.exp_be});
        chk($sformatf("v%0d maddr", i), mem_addr, v.exp_maddr);
        chk($sformatf("v%0d we", i), {31'b0, mem_we}, {31'b0, v.exp_we});
        if (v.wr) chk($sformatf("v%0d mwdata", i), mem_wdata, v.exp_mwdata);
        mem_ack = (c + 1 == v.ack_at);
      end
    end
    mem_ack = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if (!got) chk($sformatf("v%0d done_seen", i), 32'd0, 32'd1);
    else begin
      #1;
      chk($sformatf("v%0d done_stall", i), {31'b0, stall}, 32'd0);
      chk($sformatf("v%0d done_req", i), {31'b0, mem_req}, 32'd0);
      chk($sformatf("v%0d err", i), {31'b0, lsu_err}, {31'b0, v.exp_err});
      chk($sformatf("v%0d load_data", i), load_data, v.exp_ld);
      chk($sformatf("v%0d stall_cycles", i), stalls, v.exp_cyc);
      chk($sformatf("v%0d req_cycles", i), reqs, v.exp_cyc - 1);
    end
  endtask

  initial begin
    //           rd wr f3      addr          wdata         rdata        ack cyc be       maddr        we   mwdata        err  ld
    vecs.push_back('{1'b1,1'b0,3'b010,32'h100,32'h0,       32'hDEADBEEF,2,3,4'b1111,32'h100,1'b0,32'h0,       1'b0,32'hDEADBEEF});
    vecs.push_back('{1'b1,1'b0,3'b000,32'h103,32'h0,       32'h80FF0000,1,2,4'b1000,32'h100,1'b0,32'h0,       1'b0,32'hFFFFFF80});
    vecs.push_back('{1'b1,1'b0,3'b100,32'h103,32'h0,       32'h80FF0000,1,2,4'b1000,32'h100,1'b0,32'h0,       1'b0,32'h00000080});
    vecs.push_back('{1'b0,1'b1,3'b001,32'h202,32'h1234ABCD,32'h0,       1,2,4'b1100,32'h200,1'b1,32'hABCDABCD,1'b0,32'h00000080});
    vecs.push_back('{1'b1,1'b0,3'b010,32'h101,32'h0,       32'h0,       0,1,4'b0000,32'h0,  1'b0,32'h0,       1'b1,32'h00000080});
    vecs.push_back('{1'b0,1'b1,3'b001,32'h203,32'h5555,    32'h0,       0,1,4'b0000,32'h0,  1'b0,32'h0,       1'b1,32'h00000080});
    vecs.push_back('{1'b1,1'b0,3'b011,32'h100,32'h0,       32'h0,       0,1,4'b0000,32'h0,  1'b0,32'h0,       1'b1,32'h00000080});
    vecs.push_back('{1'b1,1'b1,3'b010,32'h100,32'h0,       32'h0,       0,1,4'b0000,32'h0,  1'b0,32'h0,       1'b1,32'h00000080});
    vecs.push_back('{1'b1,1'b0,3'b001,32'h102,32'h0,       32'h80011234,1,2,4'b1100,32'h100,1'b0,32'h0,       1'b0,32'hFFFF8001});
    vecs.push_back('{1'b1,1'b0,3'b101,32'h100,32'h0,       32'h8001F234,3,4,4'b0011,32'h100,1'b0,32'h0,       1'b0,32'h0000F234});
    vecs.push_back('{1'b0,1'b1,3'b000,32'h101,32'hAABBCC5A,32'h0,       1,2,4'b0010,32'h100,1'b1,32'h5A5A5A5A,1'b0,32'h0000F234});
    vecs.push_back('{1'b0,1'b1,3'b010,32'h304,32'h01234567,32'h0,       2,3,4'b1111,32'h304,1'b1,32'h01234567,1'b0,32'h0000F234});
    vecs.push_back('{1'b1,1'b0,3'b010,32'h500,32'h0,       32'h0,       0,5,4'b1111,32'h500,1'b0,32'h0,       1'b1,32'h0000F234});
    vecs.push_back('{1'b1,1'b0,3'b010,32'h500,32'h0,       32'h0BADF00D,4,5,4'b1111,32'h500,1'b0,32'h0,       1'b0,32'h0BADF00D});
    vecs.push_back('{1'b1,1'b0,3'b000,32'h100,32'h0,       32'h0000007F,1,2,4'b0001,32'h100,1'b0,32'h0,       1'b0,32'h0000007F});

    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    addr = 32'h100; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    #1;
    chk("rst stall", {31'b0, stall}, 32'd0);
    chk("rst mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst lsu_err", {31'b0, lsu_err}, 32'd0);
    chk("rst load_data", load_data, 32'd0);
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // start held through DONE is taken only once back in IDLE
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h10; mem_rdata = 32'h11112222;
    @(posedge clk); #1;
    chk("b2b busy1", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("b2b done1", {31'b0, done}, 32'd1);
    chk("b2b ld1", load_data, 32'h11112222);
    mem_ack = 1'b0; mem_rdata = 32'h33334444;
    @(posedge clk); #1;
    chk("b2b idle_done", {31'b0, done}, 32'd0);
    chk("b2b idle_req", {31'b0, mem_req}, 32'd0);
    chk("b2b idle_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("b2b busy2", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("b2b done2", {31'b0, done}, 32'd1);
    chk("b2b ld2", load_data, 32'h33334444);
    mem_ack = 1'b0; mem_read = 1'b0;

    // ack arriving while idle is ignored
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("late_ack done", {31'b0, done}, 32'd0);
    chk("late_ack req", {31'b0, mem_req}, 32'd0);
    chk("late_ack ld", load_data, 32'h33334444);
    mem_ack = 1'b0;

    // reset in the middle of an access
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    chk("midrst busy", {31'b0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst req", {31'b0, mem_req}, 32'd0);
    chk("midrst stall", {31'b0, stall}, 32'd0);
    chk("midrst ld", load_data, 32'd0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst no_done%0d", c), {31'b0, done}, 32'd0);
    end
    run_vec(99, '{1'b1,1'b0,3'b010,32'h400,32'h0,32'h13579BDF,1,2,4'b1111,32'h400,1'b0,32'h0,1'b0,32'h13579BDF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
